// File: rtl/arb_pkg.sv
// Shared types and widths for the systolic array arbiter.
// ROW_W/WDOG_W track the default array height and watchdog limit of the top.
package arb_pkg;

   localparam int unsigned ARB_ROWS           = 4;
   localparam int unsigned ARB_TIMEOUT_CYCLES = 64;
   localparam int unsigned ROW_W              = $clog2(ARB_ROWS);
   localparam int unsigned WDOG_W             = $clog2(ARB_TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select with requester-0 priority override.
module rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req_valid,
   input  logic [PTR_W-1:0]   i_rr_ptr,
   input  logic               i_bist_prio,
   output logic [NUM_REQ-1:0] o_win_c,
   output logic               o_any_c
);

   // Search upward from the pointer, wrapping, first hit wins.
   always_comb begin : pick
      logic             found;
      logic [PTR_W-1:0] idx;
      o_win_c = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         idx = PTR_W'((int'(i_rr_ptr) + k) % int'(NUM_REQ));
         if (!found && i_req_valid[idx]) begin
            o_win_c[idx] = 1'b1;
            found        = 1'b1;
         end
      end
      if (i_bist_prio && i_req_valid[0]) begin
         o_win_c = NUM_REQ'(1);
      end
   end

   assign o_any_c = |i_req_valid;

endmodule

// File: rtl/systolic_array_arbiter.sv
// Arbitrates one systolic array / OS matmul FSM between requesters, gates the
// FSM reset per job, tags result beats with their row and runs a watchdog.
module systolic_array_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned ROWS           = ARB_ROWS,
   parameter int unsigned COLS           = 4,
   parameter int unsigned WORD_SIZE      = 16,
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic                          bist_prio,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          mm_rst,
   input  logic [COLS-1:0]               mm_col_valid,
   input  logic [COLS*WORD_SIZE-1:0]     mm_bottom_out,
   output logic                          res_valid,
   output logic [ROW_W-1:0]              res_row,
   output logic [COLS*WORD_SIZE-1:0]     res_data,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          timeout_err
);

   localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W  = $clog2(ROWS + 1);
   localparam int unsigned DATA_W = COLS * WORD_SIZE;

   arb_state_t          r_state,       w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant,       w_grant_nxt;
   logic                r_busy,        w_busy_nxt;
   logic                r_mm_rst,      w_mm_rst_nxt;
   logic                r_res_valid,   w_res_valid_nxt;
   logic [ROW_W-1:0]    r_res_row,     w_res_row_nxt;
   logic [DATA_W-1:0]   r_res_data,    w_res_data_nxt;
   logic [NUM_REQ-1:0]  r_req_done,    w_req_done_nxt;
   logic                r_timeout_err, w_timeout_nxt;
   logic [PTR_W-1:0]    r_rr_ptr,      w_rr_ptr_nxt;
   logic [CNT_W-1:0]    r_beat_cnt,    w_beat_nxt;
   logic [WDOG_W-1:0]   r_wdog,        w_wdog_nxt;
   logic [NUM_REQ-1:0]  w_win;
   logic                w_any;
   logic [PTR_W-1:0]    w_owner_inc;
   logic                w_beat;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .i_req_valid (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .i_bist_prio (bist_prio),
      .o_win_c     (w_win),
      .o_any_c     (w_any)
   );

   assign w_beat = |mm_col_valid;

   // Next-state and next-register values.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_busy_nxt      = r_busy;
      w_res_valid_nxt = 1'b0;
      w_res_row_nxt   = r_res_row;
      w_res_data_nxt  = r_res_data;
      w_req_done_nxt  = '0;
      w_timeout_nxt   = r_timeout_err;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_beat_nxt      = r_beat_cnt;
      w_wdog_nxt      = r_wdog;
      w_owner_inc     = r_rr_ptr;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (r_grant[k]) w_owner_inc = PTR_W'((k + 1) % int'(NUM_REQ));
      end

      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant_nxt = w_win;
               w_busy_nxt  = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_beat_nxt    = '0;
            w_wdog_nxt    = '0;
            w_res_row_nxt = ROW_W'(ROWS - 1);
            w_state_nxt   = RUN;
         end
         RUN: begin
            w_wdog_nxt = r_wdog + WDOG_W'(1);
            if (w_beat) begin
               w_res_valid_nxt = 1'b1;
               w_res_data_nxt  = mm_bottom_out;
               w_res_row_nxt   = ROW_W'(int'(ROWS) - 1 - int'(r_beat_cnt));
               w_beat_nxt      = r_beat_cnt + CNT_W'(1);
            end
            // Completion takes precedence over a simultaneous watchdog expiry.
            if (w_beat && (r_beat_cnt == CNT_W'(ROWS - 1))) begin
               w_state_nxt = DONE;
            end else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = ERR;
            end
         end
         DONE, ERR: begin
            w_req_done_nxt = r_grant;
            w_grant_nxt    = '0;
            w_busy_nxt     = 1'b0;
            w_rr_ptr_nxt   = w_owner_inc;
            w_state_nxt    = IDLE;
            if (r_state == ERR) w_timeout_nxt = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase

      w_mm_rst_nxt = (w_state_nxt != RUN);
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_busy        <= 1'b0;
         r_mm_rst      <= 1'b1;
         r_res_valid   <= 1'b0;
         r_res_row     <= ROW_W'(ROWS - 1);
         r_res_data    <= '0;
         r_req_done    <= '0;
         r_timeout_err <= 1'b0;
         r_rr_ptr      <= '0;
         r_beat_cnt    <= '0;
         r_wdog        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_busy        <= w_busy_nxt;
         r_mm_rst      <= w_mm_rst_nxt;
         r_res_valid   <= w_res_valid_nxt;
         r_res_row     <= w_res_row_nxt;
         r_res_data    <= w_res_data_nxt;
         r_req_done    <= w_req_done_nxt;
         r_timeout_err <= w_timeout_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_beat_cnt    <= w_beat_nxt;
         r_wdog        <= w_wdog_nxt;
      end
   end

   assign grant       = r_grant;
   assign busy        = r_busy;
   assign mm_rst      = r_mm_rst;
   assign res_valid   = r_res_valid;
   assign res_row     = r_res_row;
   assign res_data    = r_res_data;
   assign req_done    = r_req_done;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_systolic_array_arbiter.sv
// Directed bench for systolic_array_arbiter: table of arbitration jobs plus
// hand sequences for watchdog expiry and mid-job reset.
module tb_systolic_array_arbiter;

   localparam int unsigned NUM_REQ   = 2;
   localparam int unsigned ROWS      = 4;
   localparam int unsigned COLS      = 4;
   localparam int unsigned WORD_SIZE = 16;
   localparam int unsigned DW        = COLS * WORD_SIZE;

   logic                clk;
   logic                rst;
   logic [NUM_REQ-1:0]  req_valid;
   logic                bist_prio;
   logic [NUM_REQ-1:0]  grant;
   logic                busy;
   logic                mm_rst;
   logic [COLS-1:0]     mm_col_valid;
   logic [DW-1:0]       mm_bottom_out;
   logic                res_valid;
   logic [1:0]          res_row;
   logic [DW-1:0]       res_data;
   logic [NUM_REQ-1:0]  req_done;
   logic                timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] req;
      logic       bp;
      logic       hold;
      logic [1:0] exp_g;
   } vec_t;

   vec_t tbl [10];

   systolic_array_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .ROWS           (ROWS),
      .COLS           (COLS),
      .WORD_SIZE      (WORD_SIZE),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .bist_prio     (bist_prio),
      .grant         (grant),
      .busy          (busy),
      .mm_rst        (mm_rst),
      .mm_col_valid  (mm_col_valid),
      .mm_bottom_out (mm_bottom_out),
      .res_valid     (res_valid),
      .res_row       (res_row),
      .res_data      (res_data),
      .req_done      (req_done),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench hung");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk(input int id, input int b);
      return {16'hC0DE, 16'(id), 16'(b), 16'(16'h1111 * (b + 1))};
   endfunction

   // One complete job: grant, LOAD, ROWS beats (with a gap), DONE pulse.
   task automatic do_job(input int id, input logic [1:0] req, input logic bp,
                         input logic hold, input logic [1:0] exp_g, input logic exp_terr);
      req_valid    = req;
      bist_prio    = bp;
      mm_col_valid = '0;
      tick();
      check($sformatf("j%0d_grant", id), 64'(grant), 64'(exp_g));
      check($sformatf("j%0d_busy", id), 64'(busy), 64'd1);
      check($sformatf("j%0d_load_mmrst", id), 64'(mm_rst), 64'd1);
      check($sformatf("j%0d_done_clr", id), 64'(req_done), 64'd0);
      if (!hold) req_valid = '0;
      tick();
      check($sformatf("j%0d_run_mmrst", id), 64'(mm_rst), 64'd0);
      check($sformatf("j%0d_run_grant", id), 64'(grant), 64'(exp_g));
      for (int b = 0; b < int'(ROWS); b++) begin
         mm_col_valid  = 4'(1 << b);
         mm_bottom_out = mk(id, b);
         tick();
         check($sformatf("j%0d_b%0d_valid", id, b), 64'(res_valid), 64'd1);
         check($sformatf("j%0d_b%0d_row", id, b), 64'(res_row), 64'(3 - b));
         check($sformatf("j%0d_b%0d_data", id, b), res_data, mk(id, b));
         mm_col_valid = '0;
         if (b == 1) begin
            tick();
            check($sformatf("j%0d_gap_valid", id), 64'(res_valid), 64'd0);
            check($sformatf("j%0d_gap_row", id), 64'(res_row), 64'd2);
         end
         if (b == int'(ROWS) - 1) begin
            check($sformatf("j%0d_done_mmrst", id), 64'(mm_rst), 64'd1);
            check($sformatf("j%0d_done_nopulse", id), 64'(req_done), 64'd0);
         end
      end
      tick();
      check($sformatf("j%0d_req_done", id), 64'(req_done), 64'(exp_g));
      check($sformatf("j%0d_end_grant", id), 64'(grant), 64'd0);
      check($sformatf("j%0d_end_busy", id), 64'(busy), 64'd0);
      check($sformatf("j%0d_end_valid", id), 64'(res_valid), 64'd0);
      check($sformatf("j%0d_terr", id), 64'(timeout_err), 64'(exp_terr));
      if (!hold) begin
         tick();
         check($sformatf("j%0d_pulse_end", id), 64'(req_done), 64'd0);
         check($sformatf("j%0d_idle_grant", id), 64'(grant), 64'd0);
      end
   endtask

   initial begin
      tbl[0] = '{req: 2'b11, bp: 1'b0, hold: 1'b1, exp_g: 2'b01};
      tbl[1] = '{req: 2'b11, bp: 1'b0, hold: 1'b1, exp_g: 2'b10};
      tbl[2] = '{req: 2'b11, bp: 1'b0, hold: 1'b1, exp_g: 2'b01};
      tbl[3] = '{req: 2'b11, bp: 1'b1, hold: 1'b1, exp_g: 2'b01};
      tbl[4] = '{req: 2'b11, bp: 1'b1, hold: 1'b1, exp_g: 2'b01};
      tbl[5] = '{req: 2'b10, bp: 1'b1, hold: 1'b0, exp_g: 2'b10};
      tbl[6] = '{req: 2'b01, bp: 1'b0, hold: 1'b0, exp_g: 2'b01};
      tbl[7] = '{req: 2'b01, bp: 1'b0, hold: 1'b0, exp_g: 2'b01};
      tbl[8] = '{req: 2'b10, bp: 1'b0, hold: 1'b0, exp_g: 2'b10};
      tbl[9] = '{req: 2'b11, bp: 1'b0, hold: 1'b0, exp_g: 2'b01};

      rst           = 1'b0;
      req_valid     = '0;
      bist_prio     = 1'b0;
      mm_col_valid  = '0;
      mm_bottom_out = '0;

      // Reset values
      repeat (3) tick();
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mmrst", 64'(mm_rst), 64'd1);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_row", 64'(res_row), 64'd3);
      check("rst_data", res_data, 64'd0);
      check("rst_done", 64'(req_done), 64'd0);
      check("rst_terr", 64'(timeout_err), 64'd0);
      rst = 1'b1;
      tick();
      check("idle_grant", 64'(grant), 64'd0);

      // Single job from requester 1; pointer returns to 0 afterwards.
      do_job(100, 2'b10, 1'b0, 1'b0, 2'b10, 1'b0);

      // Arbitration table: alternation, BIST priority, lone requesters.
      for (int i = 0; i < 10; i++) begin
         do_job(i, tbl[i].req, tbl[i].bp, tbl[i].hold, tbl[i].exp_g, 1'b0);
      end

      // Watchdog expiry with no beats (pointer is 1, only requester 0 asks).
      req_valid    = 2'b01;
      bist_prio    = 1'b0;
      mm_col_valid = '0;
      tick();
      check("wd_grant", 64'(grant), 64'd1);
      req_valid = '0;
      tick();
      check("wd_run_mmrst", 64'(mm_rst), 64'd0);
      repeat (63) tick();
      check("wd_still_run", 64'(mm_rst), 64'd0);
      check("wd_still_busy", 64'(busy), 64'd1);
      check("wd_no_err_yet", 64'(timeout_err), 64'd0);
      tick();
      check("wd_err_mmrst", 64'(mm_rst), 64'd1);
      check("wd_err_grant", 64'(grant), 64'd1);
      tick();
      check("wd_done", 64'(req_done), 64'd1);
      check("wd_terr", 64'(timeout_err), 64'd1);
      check("wd_grant_clr", 64'(grant), 64'd0);
      check("wd_busy_clr", 64'(busy), 64'd0);
      tick();
      check("wd_pulse_end", 64'(req_done), 64'd0);
      do_job(300, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1);

      // Reset in the middle of RUN after two beats.
      req_valid = 2'b01;
      tick();
      check("mr_grant", 64'(grant), 64'd1);
      req_valid = '0;
      tick();
      for (int b = 0; b < 2; b++) begin
         mm_col_valid  = 4'hF;
         mm_bottom_out = mk(400, b);
         tick();
         check($sformatf("mr_b%0d_row", b), 64'(res_row), 64'(3 - b));
      end
      mm_col_valid = '0;
      rst = 1'b0;
      tick();
      check("mr_grant_clr", 64'(grant), 64'd0);
      check("mr_busy_clr", 64'(busy), 64'd0);
      check("mr_mmrst", 64'(mm_rst), 64'd1);
      check("mr_valid", 64'(res_valid), 64'd0);
      check("mr_row", 64'(res_row), 64'd3);
      check("mr_done", 64'(req_done), 64'd0);
      check("mr_terr", 64'(timeout_err), 64'd0);
      rst = 1'b1;
      tick();
      check("mr_done_after", 64'(req_done), 64'd0);
      check("mr_idle_grant", 64'(grant), 64'd0);
      do_job(500, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
